// File: rtl/encrypt_pipe_xor_rotate_pkg.sv
// Shared types and widths for the final XOR/rotate encrypt stage.
// Key selection enum, fixed widths and the key rotation/mux helpers.
package encrypt_config;

   localparam int ROT_CNT_W = 3;
   localparam int BYTE_W    = 8;

   typedef enum logic [1:0] {
      KEY1 = 2'd0,
      KEY2 = 2'd1,
      KEY3 = 2'd2
   } key_sel_t;

   function automatic key_sel_t next_key(input key_sel_t cur);
      case (cur)
         KEY1:    return KEY2;
         KEY2:    return KEY3;
         default: return KEY1;
      endcase
   endfunction

   // Unused encoding 3 falls back to k1 so the datapath never sees an undefined key.
   function automatic logic [BYTE_W-1:0] key_mux(
      input key_sel_t          sel,
      input logic [BYTE_W-1:0] k1,
      input logic [BYTE_W-1:0] k2,
      input logic [BYTE_W-1:0] k3
   );
      case (sel)
         KEY2:    return k2;
         KEY3:    return k3;
         default: return k1;
      endcase
   endfunction

endpackage

// File: rtl/encrypt_pipe_xor_rotate_key_sched.sv
// Key rotation scheduler: three-state key FSM plus per-key byte counter.
// key_sel is the key for the byte accepted this cycle; it updates on the edge after adv.
module encrypt_key_sched
   import encrypt_config::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 adv,
   input  logic [ROT_CNT_W-1:0] rot_freq,
   output key_sel_t             key_sel
);

   key_sel_t             state_q, state_d;
   logic [ROT_CNT_W-1:0] cnt_q, cnt_d;
   logic                 rot_hit;

   // Compared one bit wider so cnt = 7 plus one never wraps back below rot_freq.
   assign rot_hit = ({1'b0, cnt_q} + 4'd1) >= {1'b0, rot_freq};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         KEY1, KEY2, KEY3: begin
            if (adv && (rot_freq != '0)) begin
               if (rot_hit) begin
                  state_d = next_key(state_q);
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = KEY1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= KEY1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign key_sel = state_q;

endmodule

// File: rtl/encrypt_pipe_xor_rotate.sv
// Final encrypt stage: XOR byte with rotating key k1/k2/k3, one registered cycle, no backpressure.
// Optional ENCRYPT_XOR_CHAIN_EN folds the previous ciphertext into the key (chain register).
module encrypt_pipe_xor_rotate
   import encrypt_config::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 mode,
   input  logic [BYTE_W-1:0]    din,
   input  logic [BYTE_W-1:0]    k1,
   input  logic [BYTE_W-1:0]    k2,
   input  logic [BYTE_W-1:0]    k3,
   input  logic [ROT_CNT_W-1:0] rot_freq,
   output logic [BYTE_W-1:0]    data_out,
   output logic                 en_out,
   output logic                 mode_out,
   output logic [1:0]           key_sel_out
);

   logic              accept;
   key_sel_t          key_sel;
   logic [BYTE_W-1:0] key_raw;
   logic [BYTE_W-1:0] key_eff;
   logic [BYTE_W-1:0] cipher;

   logic [BYTE_W-1:0] data_q, data_d;
   logic              en_q;
   logic              mode_q;
   key_sel_t          key_sel_q;

   assign accept = en && mode;

   encrypt_key_sched u_key_sched (
      .clk      (clk),
      .rst      (rst),
      .adv      (accept),
      .rot_freq (rot_freq),
      .key_sel  (key_sel)
   );

   assign key_raw = key_mux(key_sel, k1, k2, k3);

`ifdef ENCRYPT_XOR_CHAIN_EN
   logic [BYTE_W-1:0] chain_q, chain_d;

   assign key_eff = key_raw ^ chain_q;

   always_comb begin
      chain_d = chain_q;
      if (accept) begin
         chain_d = cipher;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         chain_q <= '0;
      end else begin
         chain_q <= chain_d;
      end
   end
`else
   assign key_eff = key_raw;
`endif

   assign cipher = din ^ key_eff;

   always_comb begin
      data_d = '0;
      if (en) begin
         data_d = mode ? cipher : din;
      end
   end

   // key_sel is captured every cycle so the reported key always matches data_out.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q    <= '0;
         en_q      <= 1'b0;
         mode_q    <= 1'b0;
         key_sel_q <= KEY1;
      end else begin
         data_q    <= data_d;
         en_q      <= en;
         mode_q    <= mode;
         key_sel_q <= key_sel;
      end
   end

   assign data_out    = data_q;
   assign en_out      = en_q;
   assign mode_out    = mode_q;
   assign key_sel_out = key_sel_q;

endmodule

// File: tb/tb_encrypt_pipe_xor_rotate.sv
// Bench for encrypt_pipe_xor_rotate: directed vector table then randomized run against a reference model.
module tb_encrypt_pipe_xor_rotate;

`ifdef ENCRYPT_XOR_CHAIN_EN
   localparam bit CHAIN = 1'b1;
`else
   localparam bit CHAIN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, en, mode;
   logic [7:0] din, k1, k2, k3;
   logic [2:0] rot_freq;
   logic [7:0] data_out;
   logic       en_out, mode_out;
   logic [1:0] key_sel_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   encrypt_pipe_xor_rotate dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .mode        (mode),
      .din         (din),
      .k1          (k1),
      .k2          (k2),
      .k3          (k3),
      .rot_freq    (rot_freq),
      .data_out    (data_out),
      .en_out      (en_out),
      .mode_out    (mode_out),
      .key_sel_out (key_sel_out)
   );

   typedef struct {
      string      name;
      bit         rst, en, mode;
      logic [7:0] din, k1, k2, k3;
      logic [2:0] rf;
      logic [7:0] exp_data;
      bit         exp_en;
      logic [1:0] exp_ks;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [7:0] pick(input logic [7:0] plain, input logic [7:0] chained);
      return CHAIN ? chained : plain;
   endfunction

   function automatic void add(input string nm, input bit r, input bit e, input bit m,
                               input logic [7:0] d, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [2:0] rf,
                               input logic [7:0] ed, input bit een, input logic [1:0] eks);
      vec_t v;
      v.name = nm; v.rst = r; v.en = e; v.mode = m; v.din = d;
      v.k1 = a; v.k2 = b; v.k3 = c; v.rf = rf;
      v.exp_data = ed; v.exp_en = een; v.exp_ks = eks;
      tbl.push_back(v);
   endfunction

   function automatic void add_rst();
      add("reset", 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 8'h00, 0, 2'd0);
   endfunction

   task automatic chk(input string nm, input int step, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s step %0d got %02h expected %02h", nm, step, got, exp);
      end
   endtask

   task automatic drive(input bit r, input bit e, input bit m, input logic [7:0] d,
                        input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [2:0] rf);
      rst = r; en = e; mode = m; din = d; k1 = a; k2 = b; k3 = c; rot_freq = rf;
      @(posedge clk);
      #1;
   endtask

   // Reference model: key index, bytes-used count and chain value, updated per byte.
   int         m_key;
   int         m_cnt;
   logic [7:0] m_chain;

   initial begin
      logic [7:0] rot_plain [7];
      logic [7:0] rot_chain [7];
      logic [1:0] rot_ks    [7];
      rot_plain = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h04, 8'h04, 8'h01};
      rot_chain = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h04, 8'h00, 8'h01};
      rot_ks    = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};

      // Reset held with a byte pending, then the first byte after release.
      add("rst_hold", 1, 1, 1, 8'hFF, 8'h11, 8'h00, 8'h00, 3'd0, 8'h00, 0, 2'd0);
      add("rst_hold", 1, 1, 1, 8'hFF, 8'h11, 8'h00, 8'h00, 3'd0, 8'h00, 0, 2'd0);
      add("first",    0, 1, 1, 8'h00, 8'h11, 8'h00, 8'h00, 3'd0, 8'h11, 1, 2'd0);
      add_rst();
      add("norot", 0, 1, 1, 8'h3C, 8'hA5, 8'h00, 8'h00, 3'd0, 8'h99, 1, 2'd0);
      add("norot", 0, 1, 1, 8'hFF, 8'hA5, 8'h00, 8'h00, 3'd0, pick(8'h5A, 8'hC3), 1, 2'd0);
      add_rst();
      for (int i = 0; i < 7; i++)
         add("rot2", 0, 1, 1, 8'h00, 8'h01, 8'h02, 8'h04, 3'd2,
             pick(rot_plain[i], rot_chain[i]), 1, rot_ks[i]);
      add_rst();
      add("bubble", 0, 1, 1, 8'h00, 8'h01, 8'h02, 8'h04, 3'd1, 8'h01, 1, 2'd0);
      add("bubble", 0, 0, 1, 8'h00, 8'h01, 8'h02, 8'h04, 3'd1, 8'h00, 0, 2'd1);
      add("bubble", 0, 1, 1, 8'h00, 8'h01, 8'h02, 8'h04, 3'd1, pick(8'h02, 8'h03), 1, 2'd1);
      add("bypass", 0, 1, 0, 8'h41, 8'h01, 8'h02, 8'h04, 3'd1, 8'h41, 1, 2'd2);
      add("bypass", 0, 1, 1, 8'h00, 8'h01, 8'h02, 8'h04, 3'd1, pick(8'h04, 8'h07), 1, 2'd2);
      add_rst();
      add("midrst", 0, 1, 1, 8'h00, 8'h01, 8'h02, 8'h04, 3'd1, 8'h01, 1, 2'd0);
      add("midrst", 0, 1, 1, 8'h00, 8'h01, 8'h02, 8'h04, 3'd1, pick(8'h02, 8'h03), 1, 2'd1);
      add("midrst", 1, 1, 1, 8'h00, 8'h01, 8'h02, 8'h04, 3'd1, 8'h00, 0, 2'd0);
      add("midrst", 0, 1, 1, 8'h00, 8'h01, 8'h02, 8'h04, 3'd1, 8'h01, 1, 2'd0);
      add_rst();
      add("chain", 0, 1, 1, 8'h01, 8'h10, 8'h00, 8'h00, 3'd0, 8'h11, 1, 2'd0);
      add("chain", 0, 1, 1, 8'h01, 8'h10, 8'h00, 8'h00, 3'd0, pick(8'h11, 8'h00), 1, 2'd0);
      add("chain", 0, 1, 1, 8'h01, 8'h10, 8'h00, 8'h00, 3'd0, 8'h11, 1, 2'd0);
      add_rst();
      // Lowering rot_freq below cnt+1 rotates on the very next byte.
      add("lower", 0, 1, 1, 8'h00, 8'h01, 8'h02, 8'h04, 3'd7, 8'h01, 1, 2'd0);
      add("lower", 0, 1, 1, 8'h00, 8'h01, 8'h02, 8'h04, 3'd7, pick(8'h01, 8'h00), 1, 2'd0);
      add("lower", 0, 1, 1, 8'h00, 8'h01, 8'h02, 8'h04, 3'd7, 8'h01, 1, 2'd0);
      add("lower", 0, 1, 1, 8'h00, 8'h01, 8'h02, 8'h04, 3'd2, pick(8'h01, 8'h00), 1, 2'd0);
      add("lower", 0, 1, 1, 8'h00, 8'h01, 8'h02, 8'h04, 3'd2, 8'h02, 1, 2'd1);
      add_rst();
      // rot_freq = 7: seven bytes on k1, eighth on k2.
      for (int i = 0; i < 8; i++)
         add("rf7", 0, 1, 1, 8'h00, 8'h01, 8'h02, 8'h04, 3'd7,
             (i == 7) ? pick(8'h02, 8'h03) : pick(8'h01, (i % 2 == 0) ? 8'h01 : 8'h00),
             1, (i == 7) ? 2'd1 : 2'd0);

      rst = 1'b1; en = 1'b0; mode = 1'b0; din = '0; k1 = '0; k2 = '0; k3 = '0; rot_freq = '0;

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst, tbl[i].en, tbl[i].mode, tbl[i].din,
               tbl[i].k1, tbl[i].k2, tbl[i].k3, tbl[i].rf);
         chk({tbl[i].name, ".data"}, i, data_out, tbl[i].exp_data);
         chk({tbl[i].name, ".en"},   i, {7'd0, en_out}, {7'd0, tbl[i].exp_en});
         chk({tbl[i].name, ".mode"}, i, {7'd0, mode_out}, {7'd0, tbl[i].rst ? 1'b0 : tbl[i].mode});
         chk({tbl[i].name, ".ks"},   i, {6'd0, key_sel_out}, {6'd0, tbl[i].exp_ks});
      end

      // Randomized run with the reference model.
      drive(1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0);
      m_key = 0; m_cnt = 0; m_chain = 8'h00;
      for (int i = 0; i < 600; i++) begin
         bit         r, e, m;
         logic [7:0] d;
         logic [7:0] keys [3];
         logic [2:0] rf;
         logic [7:0] ed;
         logic [1:0] eks;
         r = ($urandom_range(0, 40) == 0);
         e = ($urandom_range(0, 4) != 0);
         m = ($urandom_range(0, 5) != 0);
         d = 8'($urandom);
         keys[0] = 8'($urandom); keys[1] = 8'($urandom); keys[2] = 8'($urandom);
         rf = ($urandom_range(0, 9) == 0) ? 3'd0 : 3'($urandom_range(1, 7));

         eks = 2'(m_key);
         if (r) begin
            ed = 8'h00; eks = 2'd0;
            m_key = 0; m_cnt = 0; m_chain = 8'h00;
         end else if (!e) begin
            ed = 8'h00;
         end else if (!m) begin
            ed = d;
         end else begin
            ed = d ^ keys[m_key] ^ (CHAIN ? m_chain : 8'h00);
            m_chain = ed;
            if (rf != 0) begin
               if (m_cnt + 1 >= int'(rf)) begin
                  m_key = (m_key + 1) % 3;
                  m_cnt = 0;
               end else begin
                  m_cnt = m_cnt + 1;
               end
            end
         end

         drive(r, e, m, d, keys[0], keys[1], keys[2], rf);
         chk("rand.data", i, data_out, ed);
         chk("rand.en",   i, {7'd0, en_out}, {7'd0, !r && e});
         chk("rand.mode", i, {7'd0, mode_out}, {7'd0, !r && m});
         chk("rand.ks",   i, {6'd0, key_sel_out}, {6'd0, eks});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/encrypt_pipe_xor_rotate.md
# encrypt_pipe_xor_rotate

Final encrypt pipeline stage. It consumes the scrambled byte and key set from the shift/scramble stage and XORs the byte with one of three keys, k1, k2 or k3. The active key advances every `rot_freq` encrypted bytes. Output is registered, with one cycle of latency, and feeds the cipher output path.

## Interface
Parameters:
- none; widths are fixed by `encrypt_config`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  byte valid from the shift/scramble stage.
- `mode`  in  1  1 = encrypt, 0 = bypass.
- `din`  in  8  scrambled byte.
- `k1`, `k2`, `k3`  in  8 each  key bytes, sampled every cycle (not latched).
- `rot_freq`  in  3  bytes per key before rotation; 0 = no rotation.
- `data_out`  out  8  ciphertext byte.
- `en_out`  out  1  registered `en`.
- `mode_out`  out  1  registered `mode`.
- `key_sel_out`  out  2  key used for the current `data_out`: 0 = k1, 1 = k2, 2 = k3.

## Operation
- Key FSM has three states, encoded 0/1/2:
  - KEY1 → KEY2 → KEY3 → KEY1.
  - 3 is an illegal encoding and recovers to KEY1 on the next edge.
- `cnt`, 3 bits, is the number of bytes already encrypted with the current key.
- Accepted byte = `en` && `mode`. For each accepted byte:
  - `data_out` <= `din` ^ `key[state]`, where `key` is the selected k1/k2/k3 input sampled in that cycle.
  - If `rot_freq` == 0: state and `cnt` hold.
  - Else if `cnt` + 1 >= `rot_freq`: state advances and `cnt` <= 0.
  - Else: `cnt` <= `cnt` + 1.
  - The comparison is done at 4-bit width, so 7 + 1 does not wrap.
- The byte always uses the key in effect before the update.
- `rot_freq` is sampled every cycle. If it is lowered below `cnt` + 1, rotation happens on the next accepted byte.
- `en` && !`mode` (bypass): `data_out` <= `din`, `en_out` <= 1, state and `cnt` hold.
- !`en`: `data_out` <= 0, `en_out` <= 0, state and `cnt` hold (bubble).
- `key_sel_out` always reports the state used for the byte currently presented on `data_out`.

## Timing
- Latency is 1 cycle from `en`/`din` to `en_out`/`data_out`.
- No backpressure; one byte is accepted per cycle.
- `k1_out`/`k2_out`/`k3_out` are not forwarded.
- Reset is synchronous: `rst` = 1 at an edge gives `data_out` = 0, `en_out` = 0, `mode_out` = 0, `key_sel_out` = 0, state KEY1, `cnt` = 0.
- `rst` has priority over `en`. A byte presented in the reset cycle is dropped.
- Reset mid-stream: the first accepted byte after `rst` falls uses k1 with `cnt` = 0.
- Back-to-back bytes across a rotation boundary carry no bubble: byte N uses the old key and byte N+1 uses the new key.

## Configuration
- Macro: `ENCRYPT_XOR_CHAIN_EN`.
- Defined: adds an 8-bit `chain` register.
  - Effective key = `key[state]` ^ `chain`.
  - On each accepted byte, `chain` <= resulting ciphertext.
  - `rst` clears `chain` to 0.
  - Bypass and bubble cycles leave `chain` unchanged.
- Undefined: no `chain` register; effective key = `key[state]`.
- Port list is identical in both builds.

## Structure
- Shared package `encrypt_config` holds:
  - `typedef enum logic [1:0] {KEY1 = 0, KEY2 = 1, KEY3 = 2} key_sel_t;`
  - `ROT_CNT_W` = 3.
  - `BYTE_W` = 8.
- Sub-module `encrypt_key_sched` holds the FSM and `cnt`.
  - Inputs: `clk`, `rst`, `adv` (accepted byte), `rot_freq`.
  - Output: `key_sel` (current state).
- The top level holds the key mux, the XOR, the optional `chain` register and the output registers.

## Test plan
- Reset: hold `rst` = 1 for 2 cycles with `en` = 1, `din` = 8'hFF → all outputs 0 and `key_sel_out` = 0. Release, then `din` = 8'h00, k1 = 8'h11 → `data_out` = 8'h11 one cycle later.
- No rotation: `rot_freq` = 0, k1 = 8'hA5, `din` = 8'h3C then 8'hFF → `data_out` = 8'h99 then 8'h5A; `key_sel_out` stays 0.
- Rotation: `rot_freq` = 2, k1/k2/k3 = 01/02/04, seven bytes of 8'h00 → `data_out` = 01, 01, 02, 02, 04, 04, 01 and `key_sel_out` = 0, 0, 1, 1, 2, 2, 0.
- Bubbles and bypass: `rot_freq` = 1, keys as above.
  - Bytes 00 (en), – (no en), 00 (en) → outputs 01; then `en_out` = 0, `data_out` = 00; then 02.
  - Then `mode` = 0, `din` = 8'h41 → `data_out` = 8'h41; the next encrypt byte 00 → 04.
- Reset mid-stream: after two bytes with `rot_freq` = 1 (state KEY3), assert `rst` for 1 cycle → the next byte 00 gives `data_out` = 01, `key_sel_out` = 0.
- Chain, built with `ENCRYPT_XOR_CHAIN_EN`: `rot_freq` = 0, k1 = 8'h10, `din` = 01, 01, 01 → `data_out` = 11, 00, 11. Without the macro, the same stimulus gives 11, 11, 11.
